// File: rtl/pfd_stream_dma.sv
// Stream DMA front end for the face-detection core: Avalon-MM control slave,
// burst read master feeding a FWFT stream FIFO, and a buffered write-back master.
module pfd_stream_dma #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int BURST_W     = 10,
    parameter int MAX_BURST   = 64,
    parameter int RFIFO_DEPTH = 256,
    parameter int WFIFO_DEPTH = 16
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iCS_chip_select,
    input  logic              iCS_read,
    input  logic              iCS_write,
    input  logic [3:0]        iCS_address,
    input  logic [31:0]       iCS_write_data,
    output logic [31:0]       oCS_read_data,
    input  logic              iRM_read_data_valid,
    input  logic              iRM_wait_request,
    input  logic [DATA_W-1:0] iRM_read_data,
    output logic              oRM_read,
    output logic [ADDR_W-1:0] oRM_read_address,
    output logic [BURST_W-1:0] oRM_burst_length,
    input  logic              iWM_wait_request,
    output logic              oWM_write,
    output logic [ADDR_W-1:0] oWM_write_address,
    output logic [DATA_W-1:0] oWM_write_data,
    output logic              oOut_valid,
    output logic [DATA_W-1:0] oOut_data,
    input  logic              iOut_ready,
    input  logic              iWrreq,
    input  logic [ADDR_W-1:0] iWr_offset,
    input  logic [DATA_W-1:0] iWr_data,
    output logic              oWrite_wait_request,
    input  logic              iFinish
);
    localparam int RA_W = $clog2(RFIFO_DEPTH);
    localparam int RC_W = RA_W + 1;
    localparam int WA_W = $clog2(WFIFO_DEPTH);
    localparam int WC_W = WA_W + 1;
    localparam int WE_W = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(DATA_W / 8);
    localparam logic [RC_W-1:0]   RF_FULL = RC_W'(RFIFO_DEPTH);
    localparam logic [WC_W-1:0]   WF_FULL = WC_W'(WFIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, ABORT} stateT;
    stateT state, nextState;

    logic [31:0] srcAddr, srcLen, dstBase, burstReg, rdCount, wrCount;
    logic        done, aborted;
    logic [ADDR_W-1:0] rdPtr;
    logic [31:0]       remaining;
    logic [RC_W-1:0]   outstanding;

    logic [DATA_W-1:0] rfMem [RFIFO_DEPTH];
    logic [RA_W-1:0]   rfWr, rfRd;
    logic [RC_W-1:0]   rfCount;
    logic [WE_W-1:0]   wfMem [WFIFO_DEPTH];
    logic [WA_W-1:0]   wfWr, wfRd;
    logic [WC_W-1:0]   wfCount;
    logic [WE_W-1:0]   wfHead;
    logic              wmHold;

    logic        busy, csWr, ctrlWr, startCmd, abortCmd;
    logic [31:0] effBurst, burstLen, rfCommit, csMux;
    logic        issue, rmAcc, rmBeat, rfPush, rfPop, wfPush, wmAcc;

    assign busy     = (state != IDLE);
    assign csWr     = iCS_chip_select && iCS_write;
    assign ctrlWr   = csWr && (iCS_address == 4'd0);
    assign startCmd = ctrlWr && iCS_write_data[0] && (state == IDLE);
    assign abortCmd = ctrlWr && iCS_write_data[1] && (state == RUN || state == FLUSH);

    // A burst is only issued if every beat it returns is guaranteed a FIFO slot.
    assign effBurst = (burstReg == 32'd0) ? 32'd1 : burstReg;
    assign burstLen = (remaining < effBurst) ? remaining : effBurst;
    assign rfCommit = 32'(rfCount) + 32'(outstanding) + burstLen;
    assign issue    = (state == RUN) && !oRM_read && (remaining != 32'd0)
                    && (rfCommit <= 32'(RFIFO_DEPTH));
    assign rmAcc    = oRM_read && !iRM_wait_request;
    assign rmBeat   = iRM_read_data_valid && (outstanding != RC_W'(0));
    assign oRM_read_address = rdPtr;

    assign oOut_valid = (rfCount != RC_W'(0)) && (state != ABORT);
    assign oOut_data  = oOut_valid ? rfMem[rfRd] : '0;
    assign rfPop      = iOut_ready && oOut_valid;
    assign rfPush     = rmBeat && (state == RUN || state == FLUSH)
                      && ((rfCount != RF_FULL) || rfPop);

    // In ABORT only a beat that was already stalled on the bus stays presented.
    assign wfHead    = wfMem[wfRd];
    assign oWM_write = (wfCount != WC_W'(0))
                     && (state == RUN || state == FLUSH || (state == ABORT && wmHold));
    assign oWM_write_address = oWM_write ? ADDR_W'(dstBase) + wfHead[WE_W-1:DATA_W] * STRIDE : '0;
    assign oWM_write_data    = oWM_write ? wfHead[DATA_W-1:0] : '0;
    assign wmAcc  = oWM_write && !iWM_wait_request;
    assign oWrite_wait_request = (wfCount == WF_FULL) || (state == IDLE) || (state == ABORT);
    assign wfPush = iWrreq && !oWrite_wait_request;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:  if (startCmd) nextState = (srcLen == 32'd0) ? FLUSH : RUN;
            RUN:   if (abortCmd) nextState = ABORT;
                   else if (iFinish) nextState = FLUSH;
            FLUSH: if (abortCmd) nextState = ABORT;
                   else if (wfCount == WC_W'(0) && outstanding == RC_W'(0) && !oRM_read)
                       nextState = IDLE;
            ABORT: if (!oRM_read && outstanding == RC_W'(0) && !oWM_write) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        csMux = '0;
        case (iCS_address)
            4'd1: csMux = {29'd0, aborted, done, busy};
            4'd2: csMux = srcAddr;
            4'd3: csMux = srcLen;
            4'd4: csMux = dstBase;
            4'd5: csMux = burstReg;
            4'd6: csMux = rdCount;
            4'd7: csMux = wrCount;
            default: csMux = '0;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (rfPush) rfMem[rfWr] <= iRM_read_data;
        if (wfPush) wfMem[wfWr] <= {iWr_offset, iWr_data};
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state <= IDLE;
            srcAddr <= '0; srcLen <= '0; dstBase <= '0; burstReg <= '0;
            rdCount <= '0; wrCount <= '0; done <= 1'b0; aborted <= 1'b0;
            rdPtr <= '0; remaining <= '0; outstanding <= '0;
            oRM_read <= 1'b0; oRM_burst_length <= '0; oCS_read_data <= '0;
            rfWr <= '0; rfRd <= '0; rfCount <= '0;
            wfWr <= '0; wfRd <= '0; wfCount <= '0; wmHold <= 1'b0;
        end else begin
            state <= nextState;
            if (csWr && !busy) begin
                case (iCS_address)
                    4'd2: srcAddr <= iCS_write_data;
                    4'd3: srcLen  <= iCS_write_data;
                    4'd4: dstBase <= iCS_write_data;
                    4'd5: burstReg <= (iCS_write_data == 32'd0) ? 32'd1 :
                                      (iCS_write_data > 32'(MAX_BURST)) ? 32'(MAX_BURST) :
                                      iCS_write_data;
                    default: ;
                endcase
            end
            if (csWr && iCS_address == 4'd1) begin
                if (iCS_write_data[1]) done    <= 1'b0;
                if (iCS_write_data[2]) aborted <= 1'b0;
            end
            if (state == FLUSH && nextState == IDLE) done    <= 1'b1;
            if (state == ABORT && nextState == IDLE) aborted <= 1'b1;

            if (startCmd) begin
                rdPtr     <= ADDR_W'(srcAddr);
                remaining <= srcLen;
            end else if (rmAcc) begin
                rdPtr     <= rdPtr + ADDR_W'(oRM_burst_length) * STRIDE;
                remaining <= remaining - 32'(oRM_burst_length);
            end
            if (issue) begin
                oRM_read         <= 1'b1;
                oRM_burst_length <= BURST_W'(burstLen);
            end else if (rmAcc) begin
                oRM_read <= 1'b0;
            end
            outstanding <= outstanding + (rmAcc ? RC_W'(oRM_burst_length) : RC_W'(0))
                                       - (rmBeat ? RC_W'(1) : RC_W'(0));

            if (startCmd) begin
                rdCount <= '0;
                wrCount <= '0;
            end else begin
                if (rfPop) rdCount <= rdCount + 32'd1;
                if (wmAcc) wrCount <= wrCount + 32'd1;
            end

            if (state == ABORT) begin
                rfWr <= '0; rfRd <= '0; rfCount <= '0;
            end else begin
                if (rfPush) rfWr <= rfWr + RA_W'(1);
                if (rfPop)  rfRd <= rfRd + RA_W'(1);
                rfCount <= rfCount + RC_W'(rfPush) - RC_W'(rfPop);
            end

            if (state == ABORT && nextState == IDLE) begin
                wfWr <= '0; wfRd <= '0; wfCount <= '0;
            end else begin
                if (wfPush) wfWr <= wfWr + WA_W'(1);
                if (wmAcc)  wfRd <= wfRd + WA_W'(1);
                wfCount <= wfCount + WC_W'(wfPush) - WC_W'(wmAcc);
            end
            wmHold <= oWM_write && iWM_wait_request;

            if (iCS_chip_select && iCS_read) oCS_read_data <= csMux;
        end
    end
endmodule

// File: tb/tb_pfd_stream_dma.sv
// Directed bench for pfd_stream_dma: register table plus frame-level sequences
// driven through behavioural read/write memory slaves.
module tb_pfd_stream_dma;
    localparam int DATA_W = 32, ADDR_W = 32, BURST_W = 10;
    localparam int MAX_BURST = 64, RFIFO_DEPTH = 64, WFIFO_DEPTH = 16;

    logic iClk = 1'b0;
    logic iReset = 1'b1;
    logic iCS_chip_select = 0, iCS_read = 0, iCS_write = 0;
    logic [3:0] iCS_address = '0;
    logic [31:0] iCS_write_data = '0;
    logic [31:0] oCS_read_data;
    logic iRM_read_data_valid = 0, iRM_wait_request = 0;
    logic [DATA_W-1:0] iRM_read_data = '0;
    logic oRM_read;
    logic [ADDR_W-1:0] oRM_read_address;
    logic [BURST_W-1:0] oRM_burst_length;
    logic iWM_wait_request = 0;
    logic oWM_write;
    logic [ADDR_W-1:0] oWM_write_address;
    logic [DATA_W-1:0] oWM_write_data;
    logic oOut_valid;
    logic [DATA_W-1:0] oOut_data;
    logic iOut_ready = 0, iWrreq = 0, iFinish = 0;
    logic [ADDR_W-1:0] iWr_offset = '0;
    logic [DATA_W-1:0] iWr_data = '0;
    logic oWrite_wait_request;

    pfd_stream_dma #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .MAX_BURST(MAX_BURST),
                     .RFIFO_DEPTH(RFIFO_DEPTH), .WFIFO_DEPTH(WFIFO_DEPTH)) dut (
        .iClk(iClk), .iReset(iReset),
        .iCS_chip_select(iCS_chip_select), .iCS_read(iCS_read), .iCS_write(iCS_write),
        .iCS_address(iCS_address), .iCS_write_data(iCS_write_data), .oCS_read_data(oCS_read_data),
        .iRM_read_data_valid(iRM_read_data_valid), .iRM_wait_request(iRM_wait_request),
        .iRM_read_data(iRM_read_data), .oRM_read(oRM_read), .oRM_read_address(oRM_read_address),
        .oRM_burst_length(oRM_burst_length), .iWM_wait_request(iWM_wait_request),
        .oWM_write(oWM_write), .oWM_write_address(oWM_write_address), .oWM_write_data(oWM_write_data),
        .oOut_valid(oOut_valid), .oOut_data(oOut_data), .iOut_ready(iOut_ready),
        .iWrreq(iWrreq), .iWr_offset(iWr_offset), .iWr_data(iWr_data),
        .oWrite_wait_request(oWrite_wait_request), .iFinish(iFinish)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        bit          wr;
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
        string       name;
    } regVecT;

    int vecs = 0, errs = 0;
    logic [31:0] beatQ[$];
    logic [31:0] burstAddr[$], burstLen[$], wAddrLog[$], wDataLog[$];
    bit rmEnable = 1, wmToggle = 0, streamChk = 0;
    logic [31:0] streamBase = '0;
    int popCount = 0;

    function automatic logic [31:0] memWord(logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: behavioural slaves act on the falling edge, then return 1 unit after the rising edge.
    task automatic tick();
        @(negedge iClk);
        if (rmEnable && beatQ.size() > 0) begin
            iRM_read_data_valid = 1'b1;
            iRM_read_data = memWord(beatQ.pop_front());
        end else begin
            iRM_read_data_valid = 1'b0;
            iRM_read_data = '0;
        end
        if (oRM_read && !iRM_wait_request) begin
            burstAddr.push_back(oRM_read_address);
            burstLen.push_back(32'(oRM_burst_length));
            for (int i = 0; i < int'(oRM_burst_length); i++)
                beatQ.push_back(oRM_read_address + 32'(4 * i));
        end
        if (wmToggle) iWM_wait_request = ~iWM_wait_request;
        if (oWM_write && !iWM_wait_request) begin
            wAddrLog.push_back(oWM_write_address);
            wDataLog.push_back(oWM_write_data);
        end
        if (oOut_valid && iOut_ready) begin
            if (streamChk) chk("stream data", oOut_data, memWord(streamBase + 32'(4 * popCount)));
            popCount++;
        end
        @(posedge iClk);
        #1;
    endtask

    task automatic csWrite(logic [3:0] a, logic [31:0] d);
        iCS_chip_select = 1; iCS_write = 1; iCS_address = a; iCS_write_data = d;
        tick();
        iCS_chip_select = 0; iCS_write = 0;
    endtask

    task automatic csRead(logic [3:0] a, output logic [31:0] d);
        iCS_chip_select = 1; iCS_read = 1; iCS_address = a;
        tick();
        d = oCS_read_data;
        iCS_chip_select = 0; iCS_read = 0;
    endtask

    task automatic rdChk(logic [3:0] a, logic [31:0] exp, string name);
        logic [31:0] v;
        csRead(a, v);
        chk(name, v, exp);
    endtask

    task automatic waitIdle(logic [31:0] expStatus, string name);
        logic [31:0] v;
        int n = 0;
        do begin csRead(4'd1, v); n++; end while (v[0] && n < 400);
        chk(name, v, expStatus);
    endtask

    task automatic waitPops(int n, string name);
        int c = 0;
        while (popCount < n && c < 1000) begin tick(); c++; end
        chk(name, 32'(popCount), 32'(n));
    endtask

    task automatic newFrame(logic [31:0] src, logic [31:0] len, logic [31:0] bl);
        csWrite(4'd2, src); csWrite(4'd3, len); csWrite(4'd5, bl);
        burstAddr.delete(); burstLen.delete(); wAddrLog.delete(); wDataLog.delete();
        streamBase = src; popCount = 0;
    endtask

    task automatic finishFrame();
        iFinish = 1; tick(); iFinish = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        regVecT tbl[$];
        logic [31:0] a0, l0;
        bit stable;
        int k;

        tbl.push_back('{0, 4'd1, 32'd0, 32'd0, "status after reset"});
        tbl.push_back('{0, 4'd2, 32'd0, 32'd0, "src_addr after reset"});
        tbl.push_back('{0, 4'd3, 32'd0, 32'd0, "src_len after reset"});
        tbl.push_back('{0, 4'd5, 32'd0, 32'd0, "burst after reset"});
        tbl.push_back('{0, 4'd6, 32'd0, 32'd0, "rd_count after reset"});
        tbl.push_back('{0, 4'd7, 32'd0, 32'd0, "wr_count after reset"});
        tbl.push_back('{1, 4'd2, 32'h0000_1000, 32'd0, ""});
        tbl.push_back('{0, 4'd2, 32'd0, 32'h0000_1000, "src_addr readback"});
        tbl.push_back('{1, 4'd4, 32'hA000_0004, 32'd0, ""});
        tbl.push_back('{0, 4'd4, 32'd0, 32'hA000_0004, "dst_base readback"});
        tbl.push_back('{1, 4'd5, 32'd0, 32'd0, ""});
        tbl.push_back('{0, 4'd5, 32'd0, 32'd1, "burst clamp to 1"});
        tbl.push_back('{1, 4'd5, 32'd200, 32'd0, ""});
        tbl.push_back('{0, 4'd5, 32'd0, 32'd64, "burst clamp to max"});
        tbl.push_back('{1, 4'd9, 32'hDEAD_BEEF, 32'd0, ""});
        tbl.push_back('{0, 4'd9, 32'd0, 32'd0, "unmapped reads 0"});
        tbl.push_back('{1, 4'd6, 32'h55, 32'd0, ""});
        tbl.push_back('{0, 4'd6, 32'd0, 32'd0, "rd_count read-only"});
        tbl.push_back('{0, 4'd0, 32'd0, 32'd0, "ctrl reads 0"});

        repeat (3) tick();
        iReset = 0;
        tick();
        chk("reset oRM_read", 32'(oRM_read), 0);
        chk("reset oRM_burst_length", 32'(oRM_burst_length), 0);
        chk("reset oRM_read_address", oRM_read_address, 0);
        chk("reset oWM_write", 32'(oWM_write), 0);
        chk("reset oOut_valid", 32'(oOut_valid), 0);
        chk("reset oCS_read_data", oCS_read_data, 0);

        foreach (tbl[i]) begin
            if (tbl[i].wr) csWrite(tbl[i].a, tbl[i].d);
            else rdChk(tbl[i].a, tbl[i].exp, tbl[i].name);
        end

        // Frame 1: 100 words in bursts of 32, core always ready
        newFrame(32'h1000, 32'd100, 32'd32);
        iOut_ready = 1; streamChk = 1;
        csWrite(4'd0, 32'd1);
        chk("no read in start cycle", 32'(oRM_read), 0);
        tick();
        chk("first read one cycle after start", 32'(oRM_read), 1);
        waitPops(100, "frame1 words streamed");
        rdChk(4'd1, 32'd1, "frame1 busy before finish");
        chk("frame1 burst count", 32'(burstLen.size()), 4);
        if (burstLen.size() == 4) begin
            chk("frame1 len0", burstLen[0], 32); chk("frame1 addr0", burstAddr[0], 32'h1000);
            chk("frame1 len1", burstLen[1], 32); chk("frame1 addr1", burstAddr[1], 32'h1080);
            chk("frame1 len2", burstLen[2], 32); chk("frame1 addr2", burstAddr[2], 32'h1100);
            chk("frame1 len3", burstLen[3], 4);  chk("frame1 addr3", burstAddr[3], 32'h1180);
        end
        finishFrame();
        waitIdle(32'd2, "frame1 done");
        rdChk(4'd6, 32'd100, "frame1 rd_count");
        rdChk(4'd7, 32'd0, "frame1 wr_count");
        csWrite(4'd1, 32'd2);
        rdChk(4'd1, 32'd0, "done cleared by w1c");

        // Frame 2: core stalled, FIFO fills with one 64-beat burst
        newFrame(32'h2000, 32'd128, 32'd64);
        iOut_ready = 0;
        csWrite(4'd0, 32'd1);
        repeat (120) tick();
        chk("stalled: one burst", 32'(burstLen.size()), 1);
        chk("stalled: stream valid", 32'(oOut_valid), 1);
        rdChk(4'd6, 32'd0, "stalled: rd_count");
        iOut_ready = 1;
        repeat (63) tick();
        iOut_ready = 0;
        chk("63 words popped", 32'(popCount), 63);
        repeat (10) tick();
        chk("no burst until FIFO drains", 32'(burstLen.size()), 1);
        iOut_ready = 1;
        waitPops(128, "frame2 words streamed");
        chk("frame2 burst count", 32'(burstLen.size()), 2);
        if (burstLen.size() == 2) chk("frame2 addr1", burstAddr[1], 32'h2100);
        finishFrame();
        waitIdle(32'd2, "frame2 done");
        csWrite(4'd1, 32'd2);

        // Frame 3: read request stalled by wait_request for 5 cycles
        newFrame(32'h3000, 32'd8, 32'd8);
        iRM_wait_request = 1;
        csWrite(4'd0, 32'd1);
        tick();
        a0 = oRM_read_address; l0 = 32'(oRM_burst_length);
        stable = 1;
        repeat (5) begin
            tick();
            if (!oRM_read || oRM_read_address !== a0 || 32'(oRM_burst_length) !== l0) stable = 0;
        end
        chk("request stable under wait", 32'(stable), 1);
        chk("stalled request address", a0, 32'h3000);
        chk("stalled request length", l0, 8);
        chk("none accepted while waiting", 32'(burstLen.size()), 0);
        iRM_wait_request = 0;
        tick();
        chk("read drops after accept", 32'(oRM_read), 0);
        chk("exactly one burst accepted", 32'(burstLen.size()), 1);
        waitPops(8, "frame3 words streamed");
        finishFrame();
        waitIdle(32'd2, "frame3 done");
        csWrite(4'd1, 32'd2);

        // Frame 4: core write-back of 20 words, write master stalled then toggling
        csWrite(4'd4, 32'h8000);
        newFrame(32'h4000, 32'd4, 32'd4);
        iWM_wait_request = 1;
        csWrite(4'd0, 32'd1);
        for (k = 0; k < 16; k++) begin
            if (k == 15) chk("not full at 15 entries", 32'(oWrite_wait_request), 0);
            iWrreq = 1; iWr_offset = 32'(k); iWr_data = 32'hC0DE_0000 + 32'(k);
            tick();
        end
        iWrreq = 0;
        chk("wait_request at 16 entries", 32'(oWrite_wait_request), 1);
        chk("no write accepted while stalled", 32'(wAddrLog.size()), 0);
        wmToggle = 1;
        begin
            int c = 0;
            while (k < 20 && c < 200) begin
                bit canPush;
                iWrreq = 1; iWr_offset = 32'(k); iWr_data = 32'hC0DE_0000 + 32'(k);
                canPush = !oWrite_wait_request;
                tick();
                if (canPush) k++;
                c++;
            end
        end
        iWrreq = 0;
        chk("all 20 writes pushed", 32'(k), 20);
        finishFrame();
        rdChk(4'd1, 32'd1, "busy while writes drain");
        waitIdle(32'd2, "frame4 done");
        chk("writes accepted before done", 32'(wAddrLog.size()), 20);
        if (wAddrLog.size() == 20) begin
            for (int i = 0; i < 20; i++) begin
                chk("write address", wAddrLog[i], 32'h8000 + 32'(4 * i));
                chk("write data", wDataLog[i], 32'hC0DE_0000 + 32'(i));
            end
        end
        rdChk(4'd7, 32'd20, "frame4 wr_count");
        wmToggle = 0; iWM_wait_request = 0;
        csWrite(4'd1, 32'd2);

        // Frame 5: abort with 20 beats outstanding
        newFrame(32'h5000, 32'd20, 32'd20);
        streamChk = 0; rmEnable = 0;
        csWrite(4'd0, 32'd1);
        repeat (5) tick();
        chk("abort: one burst issued", 32'(burstLen.size()), 1);
        csWrite(4'd0, 32'd2);
        repeat (5) tick();
        rdChk(4'd1, 32'd1, "abort: busy while beats outstanding");
        rmEnable = 1;
        waitIdle(32'd4, "abort: aborted status");
        chk("abort: beats absorbed", 32'(beatQ.size()), 0);
        chk("abort: no new burst", 32'(burstLen.size()), 1);
        chk("abort: nothing streamed", 32'(popCount), 0);
        rdChk(4'd6, 32'd0, "abort: rd_count");
        csWrite(4'd1, 32'd4);
        rdChk(4'd1, 32'd0, "aborted cleared by w1c");

        // Frame 6: clean frame after abort
        newFrame(32'h6000, 32'd10, 32'd4);
        streamChk = 1;
        csWrite(4'd0, 32'd1);
        waitPops(10, "post-abort words streamed");
        chk("post-abort burst count", 32'(burstLen.size()), 3);
        if (burstLen.size() == 3) begin
            chk("post-abort last len", burstLen[2], 2);
            chk("post-abort last addr", burstAddr[2], 32'h6020);
        end
        finishFrame();
        waitIdle(32'd2, "post-abort done");
        rdChk(4'd6, 32'd10, "post-abort rd_count");
        csWrite(4'd1, 32'd2);

        // Frame 7: zero-length frame
        newFrame(32'h7000, 32'd0, 32'd8);
        csWrite(4'd0, 32'd1);
        waitIdle(32'd2, "zero-length done");
        chk("zero-length no read", 32'(burstLen.size()), 0);
        csWrite(4'd1, 32'd2);
        rdChk(4'd1, 32'd0, "zero-length done cleared");

        // Reset in the middle of a transfer
        newFrame(32'h9000, 32'd40, 32'd8);
        rmEnable = 0;
        csWrite(4'd0, 32'd1);
        repeat (5) tick();
        iReset = 1;
        tick();
        iReset = 0;
        beatQ.delete(); burstAddr.delete(); burstLen.delete();
        chk("reset mid-frame oRM_read", 32'(oRM_read), 0);
        repeat (20) tick();
        chk("no bus activity after reset", 32'(burstLen.size()), 0);
        rdChk(4'd1, 32'd0, "status after mid-frame reset");
        rdChk(4'd3, 32'd0, "src_len after mid-frame reset");
        rmEnable = 1;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
